map_responder: RTL and testbench
================================

# map_responder

PU-array-side responder for the img2col mapping stream. It consumes the mapping controller's address stream (PU number, in-window column, row, round, pixel strobe) and produces registered one-hot window-write strobes with ring-buffer row slots. It answers with per-PU completion pulses (`t_flag`) and the end-of-round shift request (`neighbour_out_flag`) that the mapping controller waits on. It sits between the mapping controller and the 28-PU convolution array.

## Interface
- `ROW`, 28: number of PUs; also the number of columns per image row.
- `K`, 5: kernel height and width; also the ring depth in rows.
- `ROUNDS`, 28: number of working rounds per image.
- `DW`, 8: pixel width.
- `clk`  in  1  single clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins an image.
- `pix_valid`  in  1  the current address/pixel beat is valid.
- `pix_in`  in  DW  pixel data.
- `pu_no`  in  6  target PU, 0..ROW-1.
- `pu_add`  in  6  column inside the window, 0..K-1.
- `map_finish`  in  1  the mapping controller has ended the image.
- `win_we`  out  ROW  one-hot write strobe into the PU window buffers.
- `win_slot`  out  3  ring row slot, 0..K-1.
- `win_col`  out  3  window column.
- `win_data`  out  DW  registered copy of `pix_in`.
- `t_flag`  out  ROW  one-hot, 1-cycle pulse: PU window row complete.
- `neighbour_out_flag`  out  ROW  bit 0 pulses for 1 cycle at end of round; the other bits are always 0.
- `round_cnt`  out  6  number of completed rounds.
- `busy`  out  1  high in FILL and RUN.
- `done`  out  1  1-cycle pulse at image end.
- `seq_err`  out  1  sticky; cleared only by `rst` or `start`.

## Operation
- **States:** IDLE, FILL, RUN, DONE.
- **IDLE.** `start` → FILL. The following are cleared: `slot_ptr`, `row_cnt`, `exp_pu`, `exp_add`, `round_cnt`, `seq_err`. `start` is ignored outside IDLE.
- **Accepted beat.** A beat is accepted when `pix_valid`=1 in FILL or RUN. For each accepted beat:
  - `win_we[pu_no]`=1, `win_slot`=`slot_ptr`, `win_col`=`pu_add`, `win_data`=`pix_in`.
- **Sequence check.** The expected order is `pu_add` 0..K-1 for `exp_pu`, then `exp_pu`+1.
  - A mismatch on `pu_no` or `pu_add` sets `seq_err`.
  - The write is still issued.
  - The expected pointers resynchronise to the received values and then advance.
- **Row end.** When `pu_add`=K-1 and `pu_no`=ROW-1, the current row is complete:
  - `slot_ptr` advances, wrapping K-1 → 0.
  - `exp_pu` returns to 0.
- **FILL.** Each completed row increments `row_cnt`. When `row_cnt` reaches K-1 (4 rows), the state moves to RUN. No `t_flag` is issued in FILL.
- **RUN, per-PU completion.** A beat with `pu_add`=K-1 for PU p pulses `t_flag[p]`.
- **RUN, round end.** A beat with p=ROW-1 additionally:
  - pulses `neighbour_out_flag[0]`;
  - increments `round_cnt`;
  - when `round_cnt` reaches ROUNDS, moves to DONE.
- **`map_finish` in FILL/RUN.** It moves the state to DONE after processing any same-cycle beat.
- **DONE.** Pulses `done` for one cycle, then returns to IDLE. `round_cnt` holds until the next `start`.
- **Beats outside FILL/RUN.** `pix_valid` in IDLE or DONE is ignored, with no strobes.
- **Range errors.** `pu_no` ≥ ROW or `pu_add` ≥ K:
  - sets `seq_err`;
  - `win_we` stays 0;
  - the pointers do not move.

## Timing
- **Reset values.** Every output is 0 after reset. The state is IDLE.
- **Write latency.** `win_*` appears 1 cycle after the accepted beat.
- **Flag latency.** `t_flag` and `neighbour_out_flag` are asserted in the same cycle as the `win_we` of the completing beat, i.e. 1 cycle after the beat.
- **Back-to-back beats.** Sustained at 1 beat per cycle, with no stalls.
- **Last beat plus `map_finish`.** When the final beat and `map_finish` arrive in the same cycle, the write and flags are issued, and `done` follows 1 cycle later.
- **Reset mid-image.** `rst` mid-image clears all state at that edge. No pending flags are emitted.
- **Arithmetic widths.**
  - `slot_ptr` is 3 bits, modulo K.
  - `row_cnt` and `round_cnt` are 6 bits and saturate at their terminal values.

## Structure
- **Shared package `img2col_pkg`:**
  - state enum `resp_state_t`;
  - `ROW`, `K`, `ROUNDS` defaults;
  - `ADDR_W`=6.
- **Sub-module `ring_ptr`:** modulo-K pointer with advance and clear inputs. All other logic stays in this module.

## Test plan
- **Reset.** Assert `rst` for 2 cycles → all outputs 0, state IDLE.
- **Full image.** `start`, then 4 FILL rows of 28×5 beats → no `t_flag`, `win_slot` cycles 0,1,2,3. Then 28 rounds → in each round, `t_flag[p]` pulses once at p's 5th beat, `neighbour_out_flag[0]` pulses 28 times in total, `round_cnt`=28, then `done`.
- **Ring wrap.** Round 1 writes use `win_slot`=4; round 2 writes use `win_slot`=0.
- **Sequence error.** Send `pu_no`=3 while 2 is expected → `seq_err`=1, `win_we[3]` is issued, and the next beat is expected at `pu_no`=3, `pu_add`=1.
- **Range error.** A beat with `pu_add`=5 → `win_we`=0, `seq_err`=1, pointers unchanged.
- **Early finish and mid-image reset.** `map_finish` in round 10 together with a beat → the write is issued, `done` follows next cycle, and `round_cnt` holds 10. `rst` mid-round → no flags afterwards, all outputs 0.

Source files
------------

// File: rtl/img2col_pkg.sv
// Shared definitions for the img2col mapping stream: array geometry defaults,
// address width and the responder state encoding.
package img2col_pkg;

    localparam int unsigned ROW_DEFAULT    = 28;
    localparam int unsigned K_DEFAULT      = 5;
    localparam int unsigned ROUNDS_DEFAULT = 28;
    localparam int unsigned ADDR_W         = 6;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StRun,
        StDone
    } resp_state_t;

endpackage

// File: rtl/ring_ptr.sv
// Modulo-Depth row pointer for the window ring buffer; clear wins over advance.
module ring_ptr #(
    parameter int unsigned Depth = 5,
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [Width-1:0] ptr
);

    localparam logic [Width-1:0] Last = Width'(Depth - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (ptr == Last) ? '0 : ptr + Width'(1);
        end
    end

endmodule

// File: rtl/map_responder.sv
// PU-array-side responder for the img2col stream: turns address beats into
// registered one-hot window writes and answers with row/round completion flags.
module map_responder
    import img2col_pkg::*;
#(
    parameter int unsigned ROW    = ROW_DEFAULT,
    parameter int unsigned K      = K_DEFAULT,
    parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
    parameter int unsigned DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [DW-1:0]     pix_in,
    input  logic [ADDR_W-1:0] pu_no,
    input  logic [ADDR_W-1:0] pu_add,
    input  logic              map_finish,
    output logic [ROW-1:0]    win_we,
    output logic [2:0]        win_slot,
    output logic [2:0]        win_col,
    output logic [DW-1:0]     win_data,
    output logic [ROW-1:0]    t_flag,
    output logic [ROW-1:0]    neighbour_out_flag,
    output logic [ADDR_W-1:0] round_cnt,
    output logic              busy,
    output logic              done,
    output logic              seq_err
);

    localparam logic [ADDR_W-1:0] LastPu    = ADDR_W'(ROW - 1);
    localparam logic [ADDR_W-1:0] LastAdd   = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] FillRows  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] LastRound = ADDR_W'(ROUNDS);

    resp_state_t       state_q, state_d;
    logic [ADDR_W-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0] round_cnt_d;
    logic [ADDR_W-1:0] exp_pu_q, exp_pu_d;
    logic [ADDR_W-1:0] exp_add_q, exp_add_d;
    logic [2:0]        slot_ptr;
    logic              active, kick, in_range, wr, col_end, row_end, err_set;
    logic [ROW-1:0]    pu_onehot;

    always_comb begin
        active    = (state_q == StFill) || (state_q == StRun);
        kick      = (state_q == StIdle) && start;
        in_range  = (pu_no <= LastPu) && (pu_add <= LastAdd);
        wr        = active && pix_valid && in_range;
        col_end   = wr && (pu_add == LastAdd);
        row_end   = col_end && (pu_no == LastPu);
        // Out-of-range beats always mismatch, so one compare covers both errors.
        err_set   = active && pix_valid
                    && (!in_range || (pu_no != exp_pu_q) || (pu_add != exp_add_q));
        pu_onehot = ROW'(1) << pu_no;
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        round_cnt_d = round_cnt;
        exp_pu_d    = exp_pu_q;
        exp_add_d   = exp_add_q;

        if (kick) begin
            row_cnt_d   = '0;
            round_cnt_d = '0;
            exp_pu_d    = '0;
            exp_add_d   = '0;
        end

        // Expectation follows what was actually received, then steps forward.
        if (wr) begin
            if (col_end) begin
                exp_add_d = '0;
                exp_pu_d  = row_end ? '0 : pu_no + ADDR_W'(1);
            end else begin
                exp_add_d = pu_add + ADDR_W'(1);
                exp_pu_d  = pu_no;
            end
        end

        if (row_end && (state_q == StFill) && (row_cnt_q != FillRows)) begin
            row_cnt_d = row_cnt_q + ADDR_W'(1);
        end
        if (row_end && (state_q == StRun) && (round_cnt != LastRound)) begin
            round_cnt_d = round_cnt + ADDR_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (start) state_d = StFill;
            end
            StFill: begin
                if (map_finish)                  state_d = StDone;
                else if (row_cnt_d == FillRows)  state_d = StRun;
            end
            StRun: begin
                if (map_finish || (round_cnt_d == LastRound)) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    ring_ptr #(
        .Depth(K),
        .Width(3)
    ) u_ring_ptr (
        .clk(clk),
        .rst(rst),
        .clr(kick),
        .adv(row_end),
        .ptr(slot_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            row_cnt_q          <= '0;
            round_cnt          <= '0;
            exp_pu_q           <= '0;
            exp_add_q          <= '0;
            seq_err            <= 1'b0;
            done               <= 1'b0;
            win_we             <= '0;
            win_slot           <= '0;
            win_col            <= '0;
            win_data           <= '0;
            t_flag             <= '0;
            neighbour_out_flag <= '0;
        end else begin
            state_q            <= state_d;
            row_cnt_q          <= row_cnt_d;
            round_cnt          <= round_cnt_d;
            exp_pu_q           <= exp_pu_d;
            exp_add_q          <= exp_add_d;
            seq_err            <= kick ? 1'b0 : (seq_err | err_set);
            done               <= (state_q == StDone);
            win_we             <= wr ? pu_onehot : '0;
            t_flag             <= (col_end && (state_q == StRun)) ? pu_onehot : '0;
            neighbour_out_flag <= (row_end && (state_q == StRun)) ? ROW'(1) : '0;
            if (wr) begin
                win_slot <= slot_ptr;
                win_col  <= pu_add[2:0];
                win_data <= pix_in;
            end
        end
    end

    assign busy = active;

endmodule

// File: tb/tb_map_responder.sv
// Self-checking bench for map_responder: random data and idle gaps checked
// against a row/round counting model of the mapping protocol.
module tb_map_responder;

    localparam int unsigned ROW    = 28;
    localparam int unsigned K      = 5;
    localparam int unsigned ROUNDS = 28;
    localparam int unsigned DW     = 8;

    logic            clk = 1'b0;
    logic            rst, start, pix_valid, map_finish;
    logic [DW-1:0]   pix_in;
    logic [5:0]      pu_no, pu_add;
    logic [ROW-1:0]  win_we, t_flag, neighbour_out_flag;
    logic [2:0]      win_slot, win_col;
    logic [DW-1:0]   win_data;
    logic [5:0]      round_cnt;
    logic            busy, done, seq_err;

    always #5 clk = ~clk;

    map_responder #(
        .ROW(ROW),
        .K(K),
        .ROUNDS(ROUNDS),
        .DW(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pix_valid(pix_valid),
        .pix_in(pix_in),
        .pu_no(pu_no),
        .pu_add(pu_add),
        .map_finish(map_finish),
        .win_we(win_we),
        .win_slot(win_slot),
        .win_col(win_col),
        .win_data(win_data),
        .t_flag(t_flag),
        .neighbour_out_flag(neighbour_out_flag),
        .round_cnt(round_cnt),
        .busy(busy),
        .done(done),
        .seq_err(seq_err)
    );

    int checks = 0;
    int failures = 0;

    // Model: 0 idle, 1 image in progress, 2 image ended (done due next cycle).
    int   m_mode, m_rows, m_round, m_exp_pu, m_exp_add;
    logic m_seq_err;
    int   nof_total, tf_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_win_we", 64'(win_we), 64'd0);
        chk("rst_win_slot", 64'(win_slot), 64'd0);
        chk("rst_win_col", 64'(win_col), 64'd0);
        chk("rst_win_data", 64'(win_data), 64'd0);
        chk("rst_t_flag", 64'(t_flag), 64'd0);
        chk("rst_nof", 64'(neighbour_out_flag), 64'd0);
        chk("rst_round_cnt", 64'(round_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_seq_err", 64'(seq_err), 64'd0);
    endtask

    task automatic reset_dut(input bit with_beat);
        rst        = 1'b1;
        start      = 1'b0;
        map_finish = 1'b0;
        pix_valid  = with_beat;
        pu_no      = 6'd13;
        pu_add     = 6'd4;
        pix_in     = 8'hA5;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        pix_valid = 1'b0;
        m_mode    = 0;
        m_rows    = 0;
        m_round   = 0;
        m_seq_err = 1'b0;
        m_exp_pu  = 0;
        m_exp_add = 0;
        chk_all_zero();
    endtask

    // One clock: drive a beat (or idle), then compare against the model.
    task automatic cycle(input bit v, input int pu, input int add, input bit fin, input bit st);
        logic [DW-1:0]  pix;
        logic [ROW-1:0] e_we, e_tf;
        bit             e_nof, e_done, finished;
        int             e_slot;
        pix      = DW'($urandom);
        e_we     = '0;
        e_tf     = '0;
        e_nof    = 1'b0;
        e_slot   = 0;
        finished = fin;
        e_done   = (m_mode == 2);

        pix_valid  = v;
        pu_no      = 6'(pu);
        pu_add     = 6'(add);
        map_finish = fin;
        start      = st;
        pix_in     = pix;
        @(posedge clk);
        #1;
        pix_valid  = 1'b0;
        map_finish = 1'b0;
        start      = 1'b0;

        if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode    = 1;
                m_rows    = 0;
                m_round   = 0;
                m_exp_pu  = 0;
                m_exp_add = 0;
                m_seq_err = 1'b0;
            end
        end else begin
            if (v) begin
                if (pu >= int'(ROW) || add >= int'(K)) begin
                    m_seq_err = 1'b1;
                end else begin
                    if (pu != m_exp_pu || add != m_exp_add) m_seq_err = 1'b1;
                    e_we[pu] = 1'b1;
                    e_slot   = m_rows % int'(K);
                    if (add == int'(K) - 1) begin
                        if (m_rows >= int'(K) - 1) e_tf[pu] = 1'b1;
                        m_exp_add = 0;
                        m_exp_pu  = (pu == int'(ROW) - 1) ? 0 : pu + 1;
                        if (pu == int'(ROW) - 1) begin
                            if (m_rows >= int'(K) - 1) begin
                                e_nof = 1'b1;
                                m_round++;
                                if (m_round == int'(ROUNDS)) finished = 1'b1;
                            end
                            m_rows++;
                        end
                    end else begin
                        m_exp_add = add + 1;
                        m_exp_pu  = pu;
                    end
                end
            end
            if (finished) m_mode = 2;
        end

        nof_total += int'(neighbour_out_flag[0]);
        tf_total  += $countones(t_flag);

        chk("win_we", 64'(win_we), 64'(e_we));
        chk("t_flag", 64'(t_flag), 64'(e_tf));
        chk("nof", 64'(neighbour_out_flag), 64'(ROW'(e_nof)));
        chk("done", 64'(done), 64'(e_done));
        chk("seq_err", 64'(seq_err), 64'(m_seq_err));
        chk("round_cnt", 64'(round_cnt), 64'(m_round));
        chk("busy", 64'(busy), 64'(m_mode == 1));
        if (e_we != '0) begin
            chk("win_slot", 64'(win_slot), 64'(e_slot));
            chk("win_col", 64'(win_col), 64'(add));
            chk("win_data", 64'(win_data), 64'(pix));
        end
    endtask

    initial begin
        nof_total = 0;
        tf_total  = 0;
        reset_dut(1'b0);

        // Image 1: full image with random gaps; a stray start mid-image is ignored.
        cycle(1'b1, 0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        for (int r = 0; r < int'(K) - 1 + int'(ROUNDS); r++) begin
            for (int p = 0; p < int'(ROW); p++) begin
                for (int a = 0; a < int'(K); a++) begin
                    if ($urandom_range(7) == 0) cycle(1'b0, 0, 0, 1'b0, 1'b0);
                    cycle(1'b1, p, a, 1'b0, (r == 6 && p == 3 && a == 2));
                end
            end
        end
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        cycle(1'b1, 5, 1, 1'b0, 1'b0);
        chk("img1_nof_total", 64'(nof_total), 64'(ROUNDS));
        chk("img1_tflag_total", 64'(tf_total), 64'(ROUNDS * ROW));
        chk("img1_round_hold", 64'(round_cnt), 64'(ROUNDS));

        // Image 2: skip PU 2, range errors, then finish with the last beat of round 10.
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        for (int r = 0; r < int'(K) - 1 + 10; r++) begin
            for (int p = 0; p < int'(ROW); p++) begin
                if (r == 5 && p == 10) begin
                    cycle(1'b1, 10, 5, 1'b0, 1'b0);
                    cycle(1'b1, 30, 0, 1'b0, 1'b0);
                end
                for (int a = 0; a < int'(K); a++) begin
                    if (!(r == 0 && p == 2)) begin
                        cycle(1'b1, p, a, (r == int'(K) + 8 && p == int'(ROW) - 1 && a == 4),
                              1'b0);
                        if (r == 0 && p == 3 && a == 0) begin
                            chk("seq_err_set", 64'(seq_err), 64'd1);
                            chk("seq_err_we3", 64'(win_we), 64'(ROW'(8)));
                        end
                    end
                end
            end
        end
        cycle(1'b0, 0, 0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 0, 0, 1'b0, 1'b0);
        chk("early_round_hold", 64'(round_cnt), 64'd10);

        // Image 3: reset in the middle of a round.
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < int'(ROW); p++) begin
                for (int a = 0; a < int'(K); a++) begin
                    if (r < 7 || p < 13) cycle(1'b1, p, a, 1'b0, 1'b0);
                end
            end
        end
        reset_dut(1'b1);
        for (int a = 0; a < int'(K); a++) cycle(1'b1, 13, a, 1'b0, 1'b0);
        cycle(1'b1, 27, 4, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
